// File: rtl/sync_filter_pkg.sv
// -----------------------------------------------------------------------------
// sync_filter_pkg
// Shared constants and width helpers for the sync_filter_bank slice.
//   DefSyncDepth    : default number of flops in each synchronizer chain
//   DefFilterCount  : default glitch-filter length in sync_clock cycles
//   counter_width() : bits needed to count from 0 up to max_count
//   settle_width()  : bits needed by the bank-level settle counter
// -----------------------------------------------------------------------------
package sync_filter_pkg;

    localparam int DefSyncDepth   = 2;
    localparam int DefFilterCount = 4;

    function automatic int counter_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic int settle_width(input int sync_depth, input int filter_count);
        return counter_width(sync_depth + filter_count);
    endfunction

endpackage

// File: rtl/sync_filter_channel.sv
// -----------------------------------------------------------------------------
// sync_filter_channel
// One bit of the filter bank: synchronizer chain, stability filter and
// rise/fall edge pulses.
// Ports:
//   sync_clock : destination-domain clock
//   reset      : synchronous, active-high reset
//   in_bit     : asynchronous level input
//   sync_bit   : synchronized and filtered level
//   rise_bit   : one-cycle pulse in the first cycle sync_bit is 1
//   fall_bit   : one-cycle pulse in the first cycle sync_bit is 0
// -----------------------------------------------------------------------------
import sync_filter_pkg::*;

module sync_filter_channel #(
    parameter int   SyncDepth   = DefSyncDepth,
    parameter int   FilterCount = DefFilterCount,
    parameter logic ResetBit    = 1'b0
) (
    input  logic sync_clock,
    input  logic reset,
    input  logic in_bit,
    output logic sync_bit,
    output logic rise_bit,
    output logic fall_bit
);

    localparam int CntWidth = counter_width(FilterCount);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(FilterCount - 1);

    logic [SyncDepth-1:0] chain;
    logic [CntWidth-1:0]  cnt;
    logic                 stage_out;
    logic                 update;

    assign stage_out = chain[SyncDepth-1];

    // The filtered level flips on the FilterCount-th consecutive cycle of
    // disagreement; the pulse registers use the same condition so a pulse
    // lines up with the first cycle of the new level.
    assign update = (stage_out != sync_bit) && (cnt == CntLast);

    always_ff @(posedge sync_clock) begin
        if (reset) begin
            chain <= {SyncDepth{ResetBit}};
        end else begin
            chain <= {chain[SyncDepth-2:0], in_bit};
        end
    end

    // Any cycle of agreement restarts the count, so only an unbroken run of
    // disagreement moves the output.
    always_ff @(posedge sync_clock) begin
        if (reset) begin
            sync_bit <= ResetBit;
            cnt      <= '0;
            rise_bit <= 1'b0;
            fall_bit <= 1'b0;
        end else begin
            rise_bit <= update & stage_out;
            fall_bit <= update & ~stage_out;
            if (stage_out == sync_bit) begin
                cnt <= '0;
            end else if (update) begin
                sync_bit <= stage_out;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CntWidth'(1);
            end
        end
    end

endmodule

// File: rtl/sync_filter_bank.sv
// -----------------------------------------------------------------------------
// sync_filter_bank
// Multi-channel synchronizer and glitch filter for asynchronous level inputs,
// with per-channel edge pulses and a bank-level "settled" flag.
// Optional feature macro: SYNC_FILTER_STICKY_EN adds sticky per-channel event
// status bits with a clear input.
// Ports:
//   sync_clock   : destination-domain clock
//   reset        : synchronous, active-high reset
//   in_data      : asynchronous level inputs, one per channel
//   sync_data    : synchronized and filtered levels
//   rise_pulse   : one-cycle pulse when sync_data[i] goes 0->1
//   fall_pulse   : one-cycle pulse when sync_data[i] goes 1->0
//   settled      : high once SyncDepth+FilterCount cycles have passed after reset
//   event_clear  : (SYNC_FILTER_STICKY_EN) per-channel clear of event_status
//   event_status : (SYNC_FILTER_STICKY_EN) sticky record of any edge pulse
// -----------------------------------------------------------------------------
import sync_filter_pkg::*;

module sync_filter_bank #(
    parameter int                     NumChannels = 4,
    parameter int                     SyncDepth   = DefSyncDepth,
    parameter int                     FilterCount = DefFilterCount,
    parameter logic [NumChannels-1:0] ResetValue  = '0
) (
    input  logic                   sync_clock,
    input  logic                   reset,
    input  logic [NumChannels-1:0] in_data,
    output logic [NumChannels-1:0] sync_data,
    output logic [NumChannels-1:0] rise_pulse,
    output logic [NumChannels-1:0] fall_pulse,
    output logic                   settled
`ifdef SYNC_FILTER_STICKY_EN
    ,
    input  logic [NumChannels-1:0] event_clear,
    output logic [NumChannels-1:0] event_status
`endif
);

    localparam int SettleCycles = SyncDepth + FilterCount;
    localparam int SettleWidth  = settle_width(SyncDepth, FilterCount);
    localparam logic [SettleWidth-1:0] SettleLast = SettleWidth'(SettleCycles - 1);

    logic [SettleWidth-1:0] settle_cnt;

    for (genvar i = 0; i < NumChannels; i++) begin : g_channel
        sync_filter_channel #(
            .SyncDepth   (SyncDepth),
            .FilterCount (FilterCount),
            .ResetBit    (ResetValue[i])
        ) u_channel (
            .sync_clock (sync_clock),
            .reset      (reset),
            .in_bit     (in_data[i]),
            .sync_bit   (sync_data[i]),
            .rise_bit   (rise_pulse[i]),
            .fall_bit   (fall_pulse[i])
        );
    end

    // The counter freezes once settled is high, which makes it saturate
    // without needing a separate compare against its maximum.
    always_ff @(posedge sync_clock) begin
        if (reset) begin
            settle_cnt <= '0;
            settled    <= 1'b0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + SettleWidth'(1);
            if (settle_cnt == SettleLast) begin
                settled <= 1'b1;
            end
        end
    end

`ifdef SYNC_FILTER_STICKY_EN
    // A pulse arriving in the same cycle as a clear keeps the bit set so no
    // event is ever lost.
    always_ff @(posedge sync_clock) begin
        if (reset) begin
            event_status <= '0;
        end else begin
            event_status <= (event_status & ~event_clear) | rise_pulse | fall_pulse;
        end
    end
`endif

endmodule

// File: tb/tb_sync_filter_bank.sv
// -----------------------------------------------------------------------------
// tb_sync_filter_bank
// Self-checking bench for sync_filter_bank (4 channels, depth 2, filter 4,
// reset value 4'b1000). Directed scenarios followed by randomized levels,
// all compared each cycle against a sliding-window reference model.
// Define SYNC_FILTER_STICKY_EN to also exercise the sticky event status.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sync_filter_bank;

    localparam int         NC = 4;
    localparam int         D  = 2;
    localparam int         F  = 4;
    localparam logic [3:0] RV = 4'b1000;

    logic       sync_clock;
    logic       reset;
    logic [3:0] in_data;
    logic [3:0] event_clear;
    logic [3:0] sync_data;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic       settled;
`ifdef SYNC_FILTER_STICKY_EN
    logic [3:0] event_status;
`endif

    int errors;
    int checks;

    sync_filter_bank #(
        .NumChannels (NC),
        .SyncDepth   (D),
        .FilterCount (F),
        .ResetValue  (RV)
    ) dut (
        .sync_clock (sync_clock),
        .reset      (reset),
        .in_data    (in_data),
        .sync_data  (sync_data),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .settled    (settled)
`ifdef SYNC_FILTER_STICKY_EN
        ,
        .event_clear  (event_clear),
        .event_status (event_status)
`endif
    );

    initial begin
        sync_clock = 1'b0;
        forever #5 sync_clock = ~sync_clock;
    end

    // Reference model: the synchronized value seen before edge n is the input
    // sampled D edges earlier; the filtered level flips when the last F
    // pre-edge synchronized values all disagree with it.
    logic [3:0] in_hist[$];
    logic [3:0] s_hist[$];
    logic [3:0] m_sd;
    logic [3:0] m_rise;
    logic [3:0] m_fall;
    logic [3:0] m_status;
    logic       m_settled;
    int         m_cycles;

    task automatic modelReset();
        in_hist.delete();
        s_hist.delete();
        repeat (D) in_hist.push_back(RV);
        repeat (F) s_hist.push_back(RV);
        m_sd      = RV;
        m_rise    = '0;
        m_fall    = '0;
        m_status  = '0;
        m_cycles  = 0;
        m_settled = 1'b0;
    endtask

    task automatic modelEdge(input logic rst, input logic [3:0] din, input logic [3:0] clr);
        logic [3:0] s_pre;
        logic [3:0] nrise;
        logic [3:0] nfall;
        logic       all_diff;
        if (rst) begin
            modelReset();
            return;
        end
        s_pre = in_hist[in_hist.size() - D];
        s_hist.push_back(s_pre);
        m_status = (m_status & ~clr) | m_rise | m_fall;
        nrise = '0;
        nfall = '0;
        for (int ch = 0; ch < NC; ch++) begin
            all_diff = 1'b1;
            for (int k = 0; k < F; k++) begin
                if (s_hist[s_hist.size() - 1 - k][ch] == m_sd[ch]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_sd[ch]  = ~m_sd[ch];
                nrise[ch] = m_sd[ch];
                nfall[ch] = ~m_sd[ch];
            end
        end
        m_rise = nrise;
        m_fall = nfall;
        in_hist.push_back(din);
        while (in_hist.size() > D + 2) void'(in_hist.pop_front());
        while (s_hist.size() > F + 2) void'(s_hist.pop_front());
        if (m_cycles < D + F) m_cycles++;
        m_settled = (m_cycles >= D + F);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model on the same edge, then
    // compare every output 1ns after the edge.
    task automatic applyStimulus(input logic rst, input logic [3:0] din, input logic [3:0] clr);
        reset       = rst;
        in_data     = din;
        event_clear = clr;
        @(posedge sync_clock);
        modelEdge(rst, din, clr);
        #1;
        checkOutput("sync_data", 32'(sync_data), 32'(m_sd));
        checkOutput("rise_pulse", 32'(rise_pulse), 32'(m_rise));
        checkOutput("fall_pulse", 32'(fall_pulse), 32'(m_fall));
        checkOutput("settled", 32'(settled), 32'(m_settled));
        checkOutput("pulse_exclusive", 32'(rise_pulse & fall_pulse), 32'(0));
`ifdef SYNC_FILTER_STICKY_EN
        checkOutput("event_status", 32'(event_status), 32'(m_status));
`endif
    endtask

    initial begin
        logic [3:0] cur;
        int         hold[NC];
        int         first_edge;
        int         first_edge2;
        int         pulse_cnt;
        int         fall_cnt;
        logic       rst;
        logic [3:0] clr;

        errors      = 0;
        checks      = 0;
        reset       = 1'b1;
        in_data     = RV;
        event_clear = '0;
        modelReset();
        cur = RV;

        // Reset for three cycles, then measure how long settled takes.
        repeat (3) applyStimulus(1'b1, cur, 4'b0);
        checkOutput("reset_sync_data", 32'(sync_data), 32'(4'b1000));
        checkOutput("reset_settled", 32'(settled), 32'(0));
        first_edge = 0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b0, cur, 4'b0);
            if (settled && first_edge == 0) first_edge = k;
        end
        checkOutput("settle_latency", 32'(first_edge), 32'(6));

        // Stable rise on channel 0.
        cur[0] = 1'b1;
        first_edge = 0;
        pulse_cnt  = 0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b0, cur, 4'b0);
            if (rise_pulse[0]) begin
                pulse_cnt++;
                if (first_edge == 0) first_edge = k;
            end
        end
        checkOutput("ch0_rise_latency", 32'(first_edge), 32'(6));
        checkOutput("ch0_rise_count", 32'(pulse_cnt), 32'(1));

        // Channel 1: 3-cycle glitch rejected, 4-cycle excursion accepted.
        pulse_cnt = 0;
        cur[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, cur, 4'b0);
            if (rise_pulse[1] || fall_pulse[1]) pulse_cnt++;
        end
        cur[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, cur, 4'b0);
            if (rise_pulse[1] || fall_pulse[1]) pulse_cnt++;
        end
        checkOutput("ch1_glitch_pulses", 32'(pulse_cnt), 32'(0));
        pulse_cnt = 0;
        fall_cnt  = 0;
        cur[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, cur, 4'b0);
            if (rise_pulse[1]) pulse_cnt++;
        end
        cur[1] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0, cur, 4'b0);
            if (rise_pulse[1]) pulse_cnt++;
            if (fall_pulse[1]) fall_cnt++;
        end
        checkOutput("ch1_exact_rise", 32'(pulse_cnt), 32'(1));
        checkOutput("ch1_exact_fall", 32'(fall_cnt), 32'(1));

        // Simultaneous rise on channel 2 and fall on channel 3.
        cur[2] = 1'b1;
        cur[3] = 1'b0;
        first_edge  = 0;
        first_edge2 = 0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b0, cur, 4'b0);
            if (rise_pulse[2] && first_edge == 0) first_edge = k;
            if (fall_pulse[3] && first_edge2 == 0) first_edge2 = k;
        end
        checkOutput("ch2_rise_latency", 32'(first_edge), 32'(6));
        checkOutput("ch3_fall_latency", 32'(first_edge2), 32'(6));

        // Reset in the middle of a pending change on channel 0.
        cur[0] = 1'b0;
        repeat (12) applyStimulus(1'b0, cur, 4'b0);
        cur[0] = 1'b1;
        repeat (3) applyStimulus(1'b0, cur, 4'b0);
        applyStimulus(1'b1, cur, 4'b0);
        checkOutput("midreset_ch0", 32'(sync_data[0]), 32'(0));
        checkOutput("midreset_settled", 32'(settled), 32'(0));
        first_edge = 0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b0, cur, 4'b0);
            if (rise_pulse[0] && first_edge == 0) first_edge = k;
        end
        checkOutput("post_reset_rise", 32'(first_edge), 32'(6));

        // Randomized levels with held durations around the filter length.
        for (int ch = 0; ch < NC; ch++) hold[ch] = 0;
        for (int n = 0; n < 600; n++) begin
            for (int ch = 0; ch < NC; ch++) begin
                if (hold[ch] == 0) begin
                    cur[ch]  = 1'($urandom_range(0, 1));
                    hold[ch] = $urandom_range(1, 7);
                end else begin
                    hold[ch]--;
                end
            end
            rst = ($urandom_range(0, 149) == 0);
            clr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            applyStimulus(rst, cur, clr);
        end

`ifdef SYNC_FILTER_STICKY_EN
        // Sticky status: set, hold, clear alone, and clear coinciding with a pulse.
        cur = RV;
        applyStimulus(1'b1, cur, 4'b0);
        repeat (8) applyStimulus(1'b0, cur, 4'b0);
        checkOutput("sticky_idle", 32'(event_status), 32'(0));
        cur[0] = 1'b1;
        first_edge = 0;
        for (int k = 1; k <= 12 && first_edge == 0; k++) begin
            applyStimulus(1'b0, cur, 4'b0);
            if (rise_pulse[0]) first_edge = k;
        end
        checkOutput("sticky_rise_seen", 32'(first_edge), 32'(6));
        applyStimulus(1'b0, cur, 4'b0);
        checkOutput("sticky_set", 32'(event_status[0]), 32'(1));
        repeat (3) applyStimulus(1'b0, cur, 4'b0);
        checkOutput("sticky_hold", 32'(event_status[0]), 32'(1));
        applyStimulus(1'b0, cur, 4'b0001);
        checkOutput("sticky_clear", 32'(event_status[0]), 32'(0));
        cur[0] = 1'b0;
        first_edge = 0;
        for (int k = 1; k <= 12 && first_edge == 0; k++) begin
            applyStimulus(1'b0, cur, 4'b0);
            if (fall_pulse[0]) first_edge = k;
        end
        checkOutput("sticky_fall_seen", 32'(first_edge), 32'(6));
        applyStimulus(1'b0, cur, 4'b0001);
        checkOutput("sticky_set_wins", 32'(event_status[0]), 32'(1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
